dmem_arbiter: RTL
=================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, word width; fixed at 32 so that 4 byte lanes exist.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, word-address width of the attached data RAM.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 p0_req  input  1  core-side port request; held stable until granted.
REQ-006 p0_we  input  1  core port write (1) / read (0).
REQ-007 p0_addr  input  ADDR_WIDTH  core port word address.
REQ-008 p0_wdata  input  DATA_WIDTH  core port write data.
REQ-009 p0_be  input  4  core port byte enables, bit i = byte lane [8i+7:8i].
REQ-010 p0_gnt  output  1  core port request accepted this cycle.
REQ-011 p0_rvalid  output  1  read data for core port valid on rdata.
REQ-012 p1_req, p1_we, p1_addr, p1_wdata, p1_be, p1_gnt, p1_rvalid  same widths/meanings for loader/debug port.
REQ-013 rdata  output  DATA_WIDTH  read data, shared by both ports, qualified by pX_rvalid.
REQ-014 mem_addr  output  ADDR_WIDTH  address to RAM.
REQ-015 mem_din  output  DATA_WIDTH  write data to RAM.
REQ-016 mem_we  output  1  RAM write enable.
REQ-017 mem_dout  input  DATA_WIDTH  RAM read data; RAM registers address, so mem_dout reflects the address presented one cycle earlier.

Function
REQ-018 FSM SHALL have states IDLE and MERGE; reset state IDLE.
REQ-019 In IDLE, a transfer SHALL occur on pX_req && pX_gnt; at most one gnt asserted per cycle; gnt combinational from req, state and priority pointer.
REQ-020 Arbitration SHALL be round-robin: single requester granted immediately; both requesting, grant the port not granted last; pointer updates on every grant; pointer resets to favour p0.
REQ-021 In MERGE, both gnt SHALL be 0.
REQ-022 Read grant (we=0) in cycle N: mem_addr=addr, mem_we=0 in N; pX_rvalid=1 and rdata=mem_dout in N+1; FSM stays IDLE, so back-to-back reads sustain one per cycle.
REQ-023 Full write (be=4'b1111) granted in N: mem_addr=addr, mem_din=wdata, mem_we=1 in N; single cycle; no rvalid.
REQ-024 Write with be=4'b0000 SHALL be granted and complete with mem_we=0 and no state change.
REQ-025 Partial write (any other be) granted in N: mem_we=0, mem_addr=addr in N; FSM to MERGE, latching port, addr, wdata, be.
REQ-026 In MERGE (N+1): mem_addr=latched addr, mem_din lane i = latched wdata lane i if be[i] else mem_dout lane i, mem_we=1; FSM to IDLE in N+2.
REQ-027 Read of an address written in the preceding cycle SHALL return the newly written word (RAM write-then-registered-address ordering).
REQ-028 Port holding req without gnt SHALL not be treated as accepted; changing its fields before gnt is a protocol violation, not checked.
REQ-029 When no grant and not MERGE: mem_we=0, mem_addr/mem_din don't-care but SHALL not toggle mem_we.
REQ-030 rvalid SHALL be registered; p0_rvalid and p1_rvalid never both 1.

Reset
REQ-031 While rst_n=0: FSM IDLE, pointer favours p0, p0_rvalid=p1_rvalid=0, mem_we=0, p0_gnt=p1_gnt=0, rdata=0.
REQ-032 Reset asserted during MERGE SHALL abandon the merge with no RAM write; first cycle after release behaves as IDLE.

Verification
REQ-033 p0 read addr 0x05 (RAM[5]=0xDEADBEEF) in cycle N -> p0_gnt=1 in N, p0_rvalid=1, rdata=0xDEADBEEF in N+1.
REQ-034 p0 and p1 both hold write requests from reset for 4 cycles -> gnt order p0,p1,p0,p1.
REQ-035 p1 write addr 0x10, wdata 0x000000AB, be=4'b0001, RAM[0x10]=0x11223344 -> mem_we=0 at grant, next cycle mem_we=1 mem_din=0x112233AB, gnt low in that cycle; subsequent read returns 0x112233AB.
REQ-036 p0 full write 0x0A=0xCAFEF00D then p0 read 0x0A next cycle -> rvalid cycle after read returns 0xCAFEF00D.
REQ-037 rst_n pulsed low during MERGE of partial write to 0x20 -> mem_we stays 0, RAM[0x20] unchanged, rvalid 0, p0 wins next contended grant.
REQ-038 Write be=4'b0000 -> gnt=1, mem_we=0 on all cycles, FSM stays IDLE.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter that lets two ports share one single-port data RAM,
// with byte-enable writes handled by a read-modify-write merge cycle.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   pX_req/we/addr/wdata/be         request from port X (0 = core, 1 = loader/debug)
//   pX_gnt                          request from port X accepted this cycle
//   pX_rvalid                       read data for port X is on rdata this cycle
//   rdata                           shared read data (zero unless a port's rvalid is high)
//   mem_addr/mem_din/mem_we         RAM address, write data, write enable
//   mem_dout                        RAM read data for the address presented one cycle earlier
module dmem_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  p0_req,
    input  logic                  p0_we,
    input  logic [ADDR_WIDTH-1:0] p0_addr,
    input  logic [DATA_WIDTH-1:0] p0_wdata,
    input  logic [3:0]            p0_be,
    output logic                  p0_gnt,
    output logic                  p0_rvalid,
    input  logic                  p1_req,
    input  logic                  p1_we,
    input  logic [ADDR_WIDTH-1:0] p1_addr,
    input  logic [DATA_WIDTH-1:0] p1_wdata,
    input  logic [3:0]            p1_be,
    output logic                  p1_gnt,
    output logic                  p1_rvalid,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_dout
);
    typedef enum logic {IDLE, MERGE} state_t;
    state_t r_state, w_next;
    // r_last = 1 means p1 was granted last, so p0 wins the next tie
    logic                  r_last;
    logic                  r_rv0, r_rv1;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [3:0]            r_be;
    logic                  w_idle, w_sel, w_any, w_we, w_full, w_part;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_wdata, w_merged;
    logic [3:0]            w_be;

    // grants are gated by rst_n so they are low for the whole reset interval
    assign w_idle = (r_state == IDLE) && rst_n;
    assign p0_gnt = w_idle && p0_req && (!p1_req || r_last);
    assign p1_gnt = w_idle && p1_req && (!p0_req || !r_last);
    assign w_sel  = p1_gnt;
    assign w_any  = p0_gnt || p1_gnt;
    assign w_we    = w_sel ? p1_we    : p0_we;
    assign w_addr  = w_sel ? p1_addr  : p0_addr;
    assign w_wdata = w_sel ? p1_wdata : p0_wdata;
    assign w_be    = w_sel ? p1_be    : p0_be;
    assign w_full = w_we && (w_be == 4'hF);
    assign w_part = w_we && (w_be != 4'hF) && (w_be != 4'h0);

    // enabled lanes from the latched write, the rest from the word the RAM returns
    for (genvar i = 0; i < 4; i++) begin : g_lane
        assign w_merged[8*i +: 8] = r_be[i] ? r_wdata[8*i +: 8] : mem_dout[8*i +: 8];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = (r_state == IDLE && w_any && w_part) ? MERGE : IDLE;
    end

    always_comb begin
        mem_we   = (r_state == MERGE) || (w_any && w_full);
        mem_addr = (r_state == MERGE) ? r_addr : w_addr;
        mem_din  = (r_state == MERGE) ? w_merged : w_wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last  <= 1'b1;
            r_rv0   <= 1'b0;
            r_rv1   <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_be    <= '0;
        end else begin
            if (w_any) r_last <= w_sel;
            r_rv0 <= p0_gnt && !p0_we;
            r_rv1 <= p1_gnt && !p1_we;
            if (w_any && w_part) begin
                r_addr  <= w_addr;
                r_wdata <= w_wdata;
                r_be    <= w_be;
            end
        end
    end

    assign p0_rvalid = r_rv0;
    assign p1_rvalid = r_rv1;
    assign rdata     = (r_rv0 || r_rv1) ? mem_dout : '0;
endmodule
